// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: shared state encoding and width helper for the UART TX scheduler.
package uart_tx_sched_pkg;

    // Scheduler sequencing states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        GUARD     = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    // Ceiling log2; returns 0 for v <= 1, callers clamp widths to at least 1
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports:
//   req_i   - request vector, one bit per requester
//   ptr_i   - index where the search starts (wraps modulo NREQ)
//   gnt_o   - one-hot winner, all zero when no request
//   idx_o   - binary index of the winner
//   any_o   - at least one request present
module rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned PW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] hi_req;
    logic [NREQ-1:0] pick;

    // Requests at or above the pointer take priority; otherwise wrap to the bottom
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            mask[i] = (PW'(i) >= ptr_i);
        end
        hi_req = req_i & mask;
        pick   = (hi_req != '0) ? hi_req : req_i;
    end

    // Lowest set bit of the selected vector wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (pick[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = PW'(i);
            end
        end
    end

    assign any_o = (req_i != '0);

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART transmitter between NREQ byte-stream requesters
// using round-robin arbitration with packet locking and a lock-stall timeout.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   req_valid     - per-requester byte available
//   req_data      - per-requester byte, requester i on [i*DW +: DW]
//   req_last      - byte closes the requester's packet
//   req_ready     - one-hot accept strobe (combinational, IDLE only)
//   tx_data       - registered byte to the UART core
//   tx_wr         - one-cycle write strobe to the UART core
//   tx_busy       - UART core is transmitting
//   grant         - registered one-hot current owner
//   locked        - packet lock held
//   lock_tmo_err  - sticky flag, set when a lock is force-released
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned DW       = 8,
    parameter int unsigned LOCK_TMO = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic [DW-1:0]      tx_data,
    output logic               tx_wr,
    input  logic               tx_busy,
    output logic [NREQ-1:0]    grant,
    output logic               locked,
    output logic               lock_tmo_err
);

    localparam int unsigned PW       = (NREQ > 1) ? clog2(NREQ) : 1;
    localparam int unsigned CW       = (LOCK_TMO > 1) ? clog2(LOCK_TMO) : 1;
    localparam int unsigned TMO_LAST = (LOCK_TMO > 0) ? (LOCK_TMO - 1) : 0;

    state_e            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              last_q, last_d;
    logic [DW-1:0]     tx_data_q, tx_data_d;
    logic              tx_wr_q, tx_wr_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   cand;
    logic [NREQ-1:0]   win_oh;
    logic [PW-1:0]     win_idx;
    logic              win_any;
    logic              accept;
    logic              owner_valid;
    logic [PW-1:0]     owner_nxt;

    // While locked only the owner may compete; grant_q holds its one-hot
    assign cand        = locked_q ? (req_valid & grant_q) : req_valid;
    assign owner_valid = req_valid[owner_q];
    assign owner_nxt   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i (cand),
        .ptr_i (ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx),
        .any_o (win_any)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            last_q    <= 1'b0;
            tx_data_q <= '0;
            tx_wr_q   <= 1'b0;
            grant_q   <= '0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            tx_data_q <= tx_data_d;
            tx_wr_q   <= tx_wr_d;
            grant_q   <= grant_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
        end
    end

    // Next-state, accept and lock bookkeeping
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        tx_data_d = tx_data_q;
        tx_wr_d   = 1'b0;
        grant_d   = grant_q;
        locked_d  = locked_q;
        err_d     = err_q;
        accept    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!tx_busy && win_any) begin
                    accept    = 1'b1;
                    tx_data_d = req_data[win_idx*DW +: DW];
                    grant_d   = win_oh;
                    owner_d   = win_idx;
                    last_d    = req_last[win_idx];
                    locked_d  = ~req_last[win_idx];
                    cnt_d     = '0;
                    tx_wr_d   = 1'b1;
                    state_d   = ISSUE;
                end else if (locked_q && !owner_valid && (LOCK_TMO != 0)) begin
                    // Owner stalled mid-packet: count, then force the lock open
                    if (cnt_q == CW'(TMO_LAST)) begin
                        locked_d = 1'b0;
                        grant_d  = '0;
                        err_d    = 1'b1;
                        ptr_d    = owner_nxt;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ISSUE: begin
                state_d = GUARD;
            end
            // The core may raise busy one cycle after the strobe, so skip a cycle
            GUARD: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = IDLE;
                    if (last_q) begin
                        ptr_d   = owner_nxt;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Accept strobe is gated by rst so every output is low during reset
    assign req_ready    = (accept && !rst) ? win_oh : '0;
    assign tx_data      = tx_data_q;
    assign tx_wr        = tx_wr_q;
    assign grant        = grant_q;
    assign locked       = locked_q;
    assign lock_tmo_err = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed and randomized bench for uart_tx_sched with a
// cycle-level reference model of the arbitration, lock and timeout rules.
module tb_uart_tx_sched;

    localparam int unsigned NREQ     = 3;
    localparam int unsigned DW       = 8;
    localparam int unsigned LOCK_TMO = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic [DW-1:0]      tx_data;
    logic               tx_wr;
    logic               tx_busy;
    logic [NREQ-1:0]    grant;
    logic               locked;
    logic               lock_tmo_err;

    uart_tx_sched #(
        .NREQ     (NREQ),
        .DW       (DW),
        .LOCK_TMO (LOCK_TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_wr        (tx_wr),
        .tx_busy      (tx_busy),
        .grant        (grant),
        .locked       (locked),
        .lock_tmo_err (lock_tmo_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester byte streams: {last, data}
    logic [DW:0]   rq [NREQ][$];
    int            prob [NREQ];
    logic [DW-1:0] tx_log [$];

    // UART busy model and stimulus knobs
    int busy_left  = 0;
    int pend_len   = 0;
    int busy_min   = 10;
    int busy_max   = 10;
    bit force_busy = 1'b0;
    bit rand_busy  = 1'b0;

    // Reference model state
    int              m_phase;
    int              m_ptr;
    int              m_owner;
    int              m_cnt;
    bit              m_locked;
    bit              m_err;
    bit              m_last;
    logic [NREQ-1:0] m_grant;
    logic [DW-1:0]   m_byte;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_ptr    = 0;
        m_owner  = 0;
        m_cnt    = 0;
        m_locked = 1'b0;
        m_err    = 1'b0;
        m_last   = 1'b0;
        m_grant  = '0;
        m_byte   = '0;
    endtask

    function automatic bit all_empty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    // Compare one cycle of DUT behaviour with the model, then advance the model
    task automatic model_step();
        logic [NREQ-1:0] exp_ready;
        logic [DW:0]     e;
        int              win;
        int              idx;
        bit              found;
        exp_ready = '0;
        found     = 1'b0;
        win       = 0;
        if (m_phase == 0 && !tx_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!found && req_valid[idx] && (!m_locked || idx == m_owner)) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
        if (found) exp_ready[win] = 1'b1;

        check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
        check_eq("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        check_eq("grant", 32'(grant), 32'(m_grant));
        check_eq("locked", 32'(locked), 32'(m_locked));
        check_eq("lock_tmo_err", 32'(lock_tmo_err), 32'(m_err));
        check_eq("tx_wr", 32'(tx_wr), 32'(m_phase == 1));
        if (m_phase == 1) check_eq("tx_data", 32'(tx_data), 32'(m_byte));

        if (m_phase == 0) begin
            if (found) begin
                e          = rq[win][0];
                m_byte     = e[DW-1:0];
                m_last     = e[DW];
                m_locked   = !e[DW];
                m_owner    = win;
                m_grant    = '0;
                m_grant[win] = 1'b1;
                m_cnt      = 0;
                m_phase    = 1;
            end else if (m_locked && !req_valid[m_owner] && LOCK_TMO != 0) begin
                if (m_cnt == LOCK_TMO - 1) begin
                    m_locked = 1'b0;
                    m_grant  = '0;
                    m_err    = 1'b1;
                    m_ptr    = (m_owner + 1) % NREQ;
                    m_cnt    = 0;
                end else begin
                    m_cnt++;
                end
            end
        end else if (m_phase >= 3 && !tx_busy) begin
            m_phase = 0;
            if (m_last) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_grant = '0;
            end
        end else begin
            m_phase++;
        end

        // Requesters retire bytes on the DUT's actual handshake
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] && rq[i].size() > 0) e = rq[i].pop_front();
        end
        if (tx_wr) begin
            tx_log.push_back(tx_data);
            pend_len = int'($urandom_range(busy_max, busy_min));
        end
    endtask

    task automatic drive();
        logic [DW:0] e;
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0 && $urandom_range(99) < prob[i]) begin
                e                     = rq[i][0];
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = e[DW-1:0];
                req_last[i]           = e[DW];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
        if (rand_busy) force_busy = ($urandom_range(99) < 4);
        // Busy rises the cycle after the write strobe and lasts pend_len cycles
        if (pend_len > 0) begin
            busy_left = pend_len;
            pend_len  = 0;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        tx_busy = force_busy || (busy_left > 0);
    endtask

    task automatic tick();
        @(negedge clk);
        if (rst) model_reset();
        else     model_step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic do_reset();
        for (int i = 0; i < NREQ; i++) rq[i].delete();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tx_log.delete();
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while (!(all_empty() && m_phase == 0 && busy_left == 0 && pend_len == 0 && !force_busy)
               && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(n < budget), 32'd1);
    endtask

    // Assert rst between edges during ISSUE or WAIT_DONE and check outputs drop at once
    task automatic reset_at(input bit in_wait, input int budget);
        int n;
        n = 0;
        while (!(in_wait ? (m_phase >= 3 && tx_busy) : (m_phase == 1)) && n < budget) begin
            tick();
            n++;
        end
        check_eq("rst_window_reached", 32'(n < budget), 32'd1);
        #1;
        if (in_wait) begin
            check_eq("pre_rst_locked", 32'(locked), 32'd1);
            check_eq("pre_rst_err", 32'(lock_tmo_err), 32'd1);
        end else begin
            check_eq("pre_rst_tx_wr", 32'(tx_wr), 32'd1);
        end
        #1 rst = 1'b1;
        #1;
        check_eq("rst_tx_wr", 32'(tx_wr), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_grant", 32'(grant), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);
        check_eq("rst_err", 32'(lock_tmo_err), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        for (int i = 0; i < NREQ; i++) prob[i] = 100;
        model_reset();

        // Reset values
        #2 rst = 1'b1;
        #1;
        check_eq("reset_ready", 32'(req_ready), 32'd0);
        check_eq("reset_tx_wr", 32'(tx_wr), 32'd0);
        check_eq("reset_tx_data", 32'(tx_data), 32'd0);
        check_eq("reset_grant", 32'(grant), 32'd0);
        check_eq("reset_locked", 32'(locked), 32'd0);
        check_eq("reset_err", 32'(lock_tmo_err), 32'd0);
        repeat (2) tick();
        rst = 1'b0;

        // Single byte, then pointer must favour requester 1
        rq[0].push_back({1'b1, 8'h41});
        drain("single_drain", 200);
        check_eq("single_size", 32'(tx_log.size()), 32'd1);
        check_eq("single_byte", 32'(tx_log[0]), 32'h41);
        check_eq("single_grant_clear", 32'(grant), 32'd0);
        rq[0].push_back({1'b1, 8'h42});
        rq[1].push_back({1'b1, 8'h43});
        drain("ptr_drain", 200);
        check_eq("ptr_size", 32'(tx_log.size()), 32'd3);
        check_eq("ptr_first", 32'(tx_log[1]), 32'h43);
        check_eq("ptr_second", 32'(tx_log[2]), 32'h42);

        // Contention: strict alternation
        do_reset();
        busy_min = 3;
        busy_max = 3;
        for (int k = 0; k < 4; k++) begin
            rq[0].push_back({1'b1, 8'hA0});
            rq[1].push_back({1'b1, 8'hB0});
        end
        drain("cont_drain", 400);
        check_eq("cont_size", 32'(tx_log.size()), 32'd8);
        for (int k = 0; k < 4; k++) begin
            check_eq("cont_seq", 32'(tx_log[k]), (k % 2 == 0) ? 32'hA0 : 32'hB0);
        end

        // Busy held externally
        do_reset();
        force_busy = 1'b1;
        rq[0].push_back({1'b1, 8'h01});
        rq[1].push_back({1'b1, 8'h02});
        for (int k = 0; k < 30; k++) begin
            tick();
            check_eq("busy_ready", 32'(req_ready), 32'd0);
            check_eq("busy_tx_wr", 32'(tx_wr), 32'd0);
        end
        force_busy = 1'b0;
        drain("busy_drain", 200);
        check_eq("busy_size", 32'(tx_log.size()), 32'd2);

        // Locked packet from requester 1 against a continuously valid requester 0
        do_reset();
        for (int k = 0; k < 3; k++) rq[0].push_back({1'b1, 8'hA0});
        rq[1].push_back({1'b0, 8'h10});
        rq[1].push_back({1'b0, 8'h11});
        rq[1].push_back({1'b1, 8'h12});
        drain("lock_drain", 400);
        check_eq("lock_size", 32'(tx_log.size()), 32'd6);
        check_eq("lock_b0", 32'(tx_log[0]), 32'hA0);
        check_eq("lock_b1", 32'(tx_log[1]), 32'h10);
        check_eq("lock_b2", 32'(tx_log[2]), 32'h11);
        check_eq("lock_b3", 32'(tx_log[3]), 32'h12);
        check_eq("lock_b4", 32'(tx_log[4]), 32'hA0);

        // Reset while the write strobe is high, on requester 2
        do_reset();
        rq[2].push_back({1'b1, 8'h77});
        reset_at(1'b0, 100);
        drain("issue_rst_drain", 200);

        // Lock timeout
        do_reset();
        rq[0].push_back({1'b0, 8'h55});
        rq[1].push_back({1'b1, 8'h66});
        drain("tmo_drain", 300);
        check_eq("tmo_size", 32'(tx_log.size()), 32'd2);
        check_eq("tmo_second", 32'(tx_log[1]), 32'h66);
        check_eq("tmo_err", 32'(lock_tmo_err), 32'd1);
        check_eq("tmo_unlocked", 32'(locked), 32'd0);

        // Reset during WAIT_DONE with lock and sticky error set; pointer back to 0
        busy_min = 20;
        busy_max = 20;
        tx_log.delete();
        rq[1].push_back({1'b0, 8'h21});
        rq[1].push_back({1'b0, 8'h22});
        rq[1].push_back({1'b1, 8'h23});
        reset_at(1'b1, 100);
        tx_log.delete();
        rq[0].push_back({1'b1, 8'h31});
        drain("wait_rst_drain", 400);
        check_eq("post_rst_first", 32'(tx_log[0]), 32'h31);
        check_eq("post_rst_err", 32'(lock_tmo_err), 32'd0);

        // Randomized traffic, occasional unterminated packets to provoke timeouts
        do_reset();
        busy_min  = 1;
        busy_max  = 8;
        rand_busy = 1'b1;
        for (int r = 0; r < NREQ; r++) begin
            for (int p = 0; p < 25; p++) begin
                int len;
                len = int'($urandom_range(4, 1));
                for (int b = 0; b < len; b++) begin
                    rq[r].push_back({(b == len - 1) && ($urandom_range(9) != 0), 8'($urandom)});
                end
            end
        end
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                for (int i = 0; i < NREQ; i++) begin
                    case ($urandom_range(2))
                        0:       prob[i] = 15;
                        1:       prob[i] = 50;
                        default: prob[i] = 100;
                    endcase
                end
            end
            tick();
        end
        rand_busy  = 1'b0;
        force_busy = 1'b0;
        for (int i = 0; i < NREQ; i++) prob[i] = 100;
        drain("rand_drain", 20000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
